// File: rtl/lab3_decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters and the decoded-select arbiter.
// master drives requests; slave (the arbiter) drives the grant side.
interface lab3_decoder_rr_arbiter_if;
   logic       enable;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       busy;

   modport master (
      output enable, req, done,
      input  grant, grant_idx, busy
   );

   modport slave (
      input  enable, req, done,
      output grant, grant_idx, busy
   );
endinterface

// File: rtl/lab3_decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters driving a one-hot decoded grant.
// Bounded tenure; priority pointer moves past each served requester.
module lab3_decoder_rr_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input logic                      clk,
   input logic                      rst,
   lab3_decoder_rr_arbiter_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   localparam logic [HOLD_W-1:0] LP_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] LP_ONE = HOLD_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_grant;
   logic [7:0]        w_grant_nxt;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_nxt;
   logic [2:0]        r_ptr;
   logic [2:0]        w_ptr_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_busy;
   logic              w_busy_nxt;

   logic [15:0]       w_dbl;
   logic [7:0]        w_rot;
   logic [2:0]        w_off;
   logic              w_found;
   logic [2:0]        w_pick;
   logic              w_release;

   // Rotate requests so bit 0 is the current highest-priority requester
   always_comb begin
      w_dbl   = {bus.req, bus.req} >> r_ptr;
      w_rot   = w_dbl[7:0];
      w_found = |w_rot;
      w_off   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_rot[k]) w_off = 3'(k);
      end
      w_pick = r_ptr + w_off;
   end

   // Any one of these ends the current tenure this cycle
   always_comb begin
      w_release = bus.done
                | ~bus.req[r_idx]
                | ~bus.enable
                | (r_hold == LP_MAX);
   end

   // Next-state and registered-output values
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold;
      w_busy_nxt  = r_busy;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.enable && w_found) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = w_pick;
               w_grant_nxt = 8'b1 << w_pick;
               w_busy_nxt  = 1'b1;
               w_hold_nxt  = LP_ONE;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = 8'h00;
               w_busy_nxt  = 1'b0;
               w_ptr_nxt   = r_idx + 3'd1;
               w_hold_nxt  = '0;
            end else if (r_hold != LP_MAX) begin
               w_hold_nxt = r_hold + LP_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_grant <= 8'h00;
         r_idx   <= 3'd0;
         r_ptr   <= 3'd0;
         r_hold  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_hold  <= w_hold_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign bus.grant     = r_grant;
   assign bus.grant_idx = r_idx;
   assign bus.busy      = r_busy;

endmodule
